stack_alu_gen: RTL and testbench

Parametrised stack-machine ALU. On a start strobe it pops two operands from the shared operand stack, runs one of eight operations selected by `op`, pushes the result back unless the operation is CMP, and updates the Z/S/C/V flags. It sits between the instruction decoder, which drives `en` and `op`, and the stack block. It adds a wider operation set, carry and overflow flags, stack-underflow detection and a busy indication. All outputs have defined, non-tri-stated values at all times.

---
 rtl/stack_alu_pkg.sv | 39 +++
 rtl/stack_alu_core.sv | 62 ++++++
 rtl/stack_alu_gen.sv | 163 ++++++++++++++++
 tb/tb_stack_alu_gen.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/stack_alu_pkg.sv
// Shared types and constants for the stack-machine ALU.
package stack_alu_pkg;

  // Cycles from pop request to valid top-of-stack data
  localparam int unsigned RD_LAT = 2;
  localparam int unsigned LAT_W  = 2;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SAR = 3'd6,
    OP_CMP = 3'd7
  } alu_op_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_POP1,
    ST_WAIT1,
    ST_LD1,
    ST_POP2,
    ST_WAIT2,
    ST_LD2,
    ST_EXEC,
    ST_PUSH,
    ST_DONE
  } alu_state_e;

  typedef struct packed {
    logic z;
    logic s;
    logic c;
    logic v;
  } alu_flags_t;

endpackage

// File: rtl/stack_alu_core.sv
// Combinational datapath: result and flags for one opcode.
module stack_alu_core
  import stack_alu_pkg::*;
#(
  parameter int unsigned DATA_LEN = 8,
  parameter int unsigned SH_W     = $clog2(DATA_LEN)
) (
  input  alu_op_e             op,
  input  logic [DATA_LEN-1:0] op1,
  input  logic [DATA_LEN-1:0] op2,
  output logic [DATA_LEN-1:0] result,
  output alu_flags_t          flags
);

  localparam int unsigned MSB = DATA_LEN - 1;

  logic [SH_W-1:0]          sh;
  logic [DATA_LEN:0]        sum_w;
  logic [DATA_LEN:0]        dif_w;
  logic [DATA_LEN:0]        shl_w;
  logic signed [DATA_LEN:0] sar_in;
  logic signed [DATA_LEN:0] sar_w;

  // Extra bit on each side of the shifters catches the last bit shifted out
  always_comb begin
    sh     = op1[SH_W-1:0];
    sum_w  = {1'b0, op2} + {1'b0, op1};
    dif_w  = {1'b0, op2} - {1'b0, op1};
    shl_w  = {1'b0, op2} << sh;
    sar_in = {op2, 1'b0};
    sar_w  = sar_in >>> sh;
    result = '0;
    flags  = '0;
    case (op)
      OP_ADD: begin
        result  = sum_w[MSB:0];
        flags.c = sum_w[DATA_LEN];
        flags.v = (op2[MSB] == op1[MSB]) && (sum_w[MSB] != op2[MSB]);
      end
      OP_SUB, OP_CMP: begin
        result  = dif_w[MSB:0];
        flags.c = dif_w[DATA_LEN];
        flags.v = (op2[MSB] != op1[MSB]) && (dif_w[MSB] != op2[MSB]);
      end
      OP_AND: result = op2 & op1;
      OP_OR:  result = op2 | op1;
      OP_XOR: result = op2 ^ op1;
      OP_SHL: begin
        result  = shl_w[MSB:0];
        flags.c = shl_w[DATA_LEN];
      end
      OP_SAR: begin
        result  = sar_w[DATA_LEN:1];
        flags.c = sar_w[0];
      end
      default: result = '0;
    endcase
    flags.z = (result == '0);
    flags.s = result[MSB];
  end

endmodule

// File: rtl/stack_alu_gen.sv
// Stack-machine ALU: pops two operands, executes, pushes result, updates flags.
module stack_alu_gen
  import stack_alu_pkg::*;
#(
  parameter int unsigned DATA_LEN = 8,
  parameter int unsigned SH_W     = $clog2(DATA_LEN)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                en,
  input  logic [2:0]          op,
  input  logic [DATA_LEN-1:0] stk_data_out,
  input  logic                stk_empty,
  output logic                stk_pop,
  output logic                stk_push,
  output logic [DATA_LEN-1:0] stk_data_in,
  output logic                z_flag,
  output logic                s_flag,
  output logic                c_flag,
  output logic                v_flag,
  output logic                err,
  output logic                busy,
  output logic                fin_sig
);

  alu_state_e          state_q, state_d;
  alu_op_e             op_q, op_d;
  logic [DATA_LEN-1:0] op1_q, op1_d, op2_q, op2_d, res_q, res_d;
  alu_flags_t          fnext_q, fnext_d, flags_q, flags_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic                uf_q, uf_d;
  logic                pop_d, push_d, err_d, busy_d, fin_d;
  logic [DATA_LEN-1:0] din_d;
  logic [DATA_LEN-1:0] core_res;
  alu_flags_t          core_flags;

  stack_alu_core #(
    .DATA_LEN (DATA_LEN),
    .SH_W     (SH_W)
  ) u_core (
    .op     (op_q),
    .op1    (op1_q),
    .op2    (op2_q),
    .result (core_res),
    .flags  (core_flags)
  );

  assign z_flag = flags_q.z;
  assign s_flag = flags_q.s;
  assign c_flag = flags_q.c;
  assign v_flag = flags_q.v;

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_ADD;
      op1_q       <= '0;
      op2_q       <= '0;
      res_q       <= '0;
      fnext_q     <= '0;
      flags_q     <= '0;
      lat_q       <= '0;
      uf_q        <= 1'b0;
      stk_pop     <= 1'b0;
      stk_push    <= 1'b0;
      stk_data_in <= '0;
      err         <= 1'b0;
      busy        <= 1'b0;
      fin_sig     <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      res_q       <= res_d;
      fnext_q     <= fnext_d;
      flags_q     <= flags_d;
      lat_q       <= lat_d;
      uf_q        <= uf_d;
      stk_pop     <= pop_d;
      stk_push    <= push_d;
      stk_data_in <= din_d;
      err         <= err_d;
      busy        <= busy_d;
      fin_sig     <= fin_d;
    end
  end

  // Next-state and next-output logic; underflow jumps straight to DONE
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    res_d   = res_q;
    fnext_d = fnext_q;
    flags_d = flags_q;
    lat_d   = lat_q;
    uf_d    = uf_q;
    pop_d   = 1'b0;
    push_d  = 1'b0;
    din_d   = stk_data_in;
    err_d   = err;
    busy_d  = (state_q != ST_IDLE);
    fin_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          op_d    = alu_op_e'(op);
          err_d   = 1'b0;
          uf_d    = 1'b0;
          state_d = ST_POP1;
        end
      end
      ST_POP1, ST_POP2: begin
        if (stk_empty) begin
          uf_d    = 1'b1;
          state_d = ST_DONE;
        end else begin
          pop_d   = 1'b1;
          lat_d   = LAT_W'(RD_LAT - 2);
          state_d = (state_q == ST_POP1) ? ST_WAIT1 : ST_WAIT2;
        end
      end
      ST_WAIT1, ST_WAIT2: begin
        if (lat_q == '0) begin
          state_d = (state_q == ST_WAIT1) ? ST_LD1 : ST_LD2;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      ST_LD1: begin
        op1_d   = stk_data_out;
        state_d = ST_POP2;
      end
      ST_LD2: begin
        op2_d   = stk_data_out;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        res_d   = core_res;
        fnext_d = core_flags;
        state_d = ST_PUSH;
      end
      ST_PUSH: begin
        flags_d = fnext_q;
        if (op_q != OP_CMP) begin
          push_d = 1'b1;
          din_d  = res_q;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        fin_d   = 1'b1;
        err_d   = uf_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_stack_alu_gen.sv
// Directed bench with a stack model and push-data scoreboard.
module tb_stack_alu_gen;

  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          en;
  logic [2:0]    op;
  logic [DW-1:0] stk_data_out;
  logic          stk_empty;
  logic          stk_pop, stk_push;
  logic [DW-1:0] stk_data_in;
  logic          z_flag, s_flag, c_flag, v_flag;
  logic          err, busy, fin_sig;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] stack_q[$];
  logic [DW-1:0] exp_q[$];

  stack_alu_gen #(.DATA_LEN(DW)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .en           (en),
    .op           (op),
    .stk_data_out (stk_data_out),
    .stk_empty    (stk_empty),
    .stk_pop      (stk_pop),
    .stk_push     (stk_push),
    .stk_data_in  (stk_data_in),
    .z_flag       (z_flag),
    .s_flag       (s_flag),
    .c_flag       (c_flag),
    .v_flag       (v_flag),
    .err          (err),
    .busy         (busy),
    .fin_sig      (fin_sig)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Stack model: applies the pop/push the DUT presented at the last edge
  task automatic upd(input logic p, input logic u, input logic [DW-1:0] d);
    if (p) begin
      chk("pop_nonempty", 32'(stack_q.size() != 0), 32'd1);
      if (stack_q.size() != 0) stk_data_out = stack_q.pop_back();
    end
    if (u) begin
      stack_q.push_back(d);
      chk("push_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("push_data", 32'(d), 32'(exp_q.pop_front()));
    end
    stk_empty = (stack_q.size() == 0);
  endtask

  task automatic load(input int n, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [DW-1:0] c);
    stack_q.delete();
    if (n > 0) stack_q.push_back(a);
    if (n > 1) stack_q.push_back(b);
    if (n > 2) stack_q.push_back(c);
    stk_empty = (stack_q.size() == 0);
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic push_e,
                        input logic [DW-1:0] res_e, input logic [3:0] fl_e,
                        input logic err_e, input int fin_e, input logic [31:0] pmask_e,
                        input int depth_e, input int busy_en, input int abort_at);
    int fin_at = -1, push_at = -1, busy_fall = -1, both = 0;
    logic [31:0] pmask = '0;
    logic busy_seen = 1'b0, aborted = 1'b0;
    logic pp, pu;
    logic [DW-1:0] pd;
    if (push_e) exp_q.push_back(res_e);
    @(negedge clk);
    en = 1'b1;
    op = o;
    @(posedge clk);
    #1;
    en = 1'b0;
    op = 3'($urandom_range(0, 7));
    chk({name, "_err_clr"}, 32'(err), 32'd0);
    pp = stk_pop; pu = stk_push; pd = stk_data_in;
    for (int k = 1; k <= 13; k++) begin
      @(posedge clk);
      #1;
      upd(pp, pu, pd);
      if (stk_pop) pmask[k] = 1'b1;
      if (stk_push && push_at < 0) push_at = k;
      if (stk_pop && stk_push) both++;
      if (fin_sig && fin_at < 0) fin_at = k;
      if (busy) busy_seen = 1'b1;
      if (busy_seen && !busy && busy_fall < 0) busy_fall = k;
      en = (k == busy_en);
      pp = stk_pop; pu = stk_push; pd = stk_data_in;
      if (k == abort_at) begin
        #2 rstn = 1'b0;
        #1;
        chk({name, "_rst_pop"}, 32'(stk_pop), 32'd0);
        chk({name, "_rst_push"}, 32'(stk_push), 32'd0);
        chk({name, "_rst_busy"}, 32'(busy), 32'd0);
        chk({name, "_rst_fin"}, 32'(fin_sig), 32'd0);
        chk({name, "_rst_err"}, 32'(err), 32'd0);
        chk({name, "_rst_flags"}, 32'({z_flag, s_flag, c_flag, v_flag}), 32'd0);
        aborted = 1'b1;
        break;
      end
    end
    en = 1'b0;
    if (aborted) begin
      stack_q.delete();
      exp_q.delete();
      stk_empty = 1'b1;
      @(negedge clk);
      rstn = 1'b1;
    end else begin
      chk({name, "_fin_cycle"}, 32'(fin_at), 32'(fin_e));
      chk({name, "_pop_cycles"}, pmask, pmask_e);
      chk({name, "_push_cycle"}, 32'(push_at), push_e ? 32'd8 : 32'hFFFF_FFFF);
      chk({name, "_busy_fall"}, 32'(busy_fall), 32'(fin_e + 1));
      chk({name, "_flags"}, 32'({z_flag, s_flag, c_flag, v_flag}), 32'(fl_e));
      chk({name, "_err"}, 32'(err), 32'(err_e));
      chk({name, "_pop_push_excl"}, 32'(both), 32'd0);
      chk({name, "_push_missing"}, 32'(exp_q.size()), 32'd0);
      chk({name, "_depth"}, 32'(stack_q.size()), 32'(depth_e));
    end
  endtask

  initial begin
    rstn         = 1'b0;
    en           = 1'b0;
    op           = 3'd0;
    stk_data_out = '0;
    stk_empty    = 1'b1;
    #12;
    chk("reset_outputs",
        32'({stk_pop, stk_push, busy, fin_sig, err, z_flag, s_flag, c_flag, v_flag}), 32'd0);
    chk("reset_data_in", 32'(stk_data_in), 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // name, op, push?, result, {z,s,c,v}, err, fin cycle, pop mask, depth, busy-en, abort
    load(2, 8'h05, 8'h03, 8'h00);
    run_op("add_5_3",   3'd0, 1'b1, 8'h08, 4'b0000, 1'b0, 9, 32'h12, 1, 0, 0);
    load(2, 8'hFF, 8'h01, 8'h00);
    run_op("add_wrap",  3'd0, 1'b1, 8'h00, 4'b1010, 1'b0, 9, 32'h12, 1, 0, 0);
    load(2, 8'h80, 8'h01, 8'h00);
    run_op("sub_ovf",   3'd1, 1'b1, 8'h7F, 4'b0001, 1'b0, 9, 32'h12, 1, 0, 0);
    load(2, 8'h80, 8'h02, 8'h00);
    run_op("sar",       3'd6, 1'b1, 8'hE0, 4'b0100, 1'b0, 9, 32'h12, 1, 0, 0);
    load(2, 8'h81, 8'h01, 8'h00);
    run_op("shl",       3'd5, 1'b1, 8'h02, 4'b0010, 1'b0, 9, 32'h12, 1, 0, 0);
    load(2, 8'h07, 8'h07, 8'h00);
    run_op("cmp_eq",    3'd7, 1'b0, 8'h00, 4'b1000, 1'b0, 9, 32'h12, 0, 3, 0);
    load(2, 8'hF0, 8'h3C, 8'h00);
    run_op("and",       3'd2, 1'b1, 8'h30, 4'b0000, 1'b0, 9, 32'h12, 1, 8, 0);
    load(2, 8'hF0, 8'h3C, 8'h00);
    run_op("or",        3'd3, 1'b1, 8'hFC, 4'b0100, 1'b0, 9, 32'h12, 1, 0, 0);
    load(2, 8'h3C, 8'h3C, 8'h00);
    run_op("xor",       3'd4, 1'b1, 8'h00, 4'b1000, 1'b0, 9, 32'h12, 1, 0, 0);
    load(1, 8'h09, 8'h00, 8'h00);
    run_op("uf_pop2",   3'd0, 1'b0, 8'h00, 4'b1000, 1'b1, 5, 32'h02, 0, 0, 0);
    load(0, 8'h00, 8'h00, 8'h00);
    run_op("uf_pop1",   3'd0, 1'b0, 8'h00, 4'b1000, 1'b1, 2, 32'h00, 0, 0, 0);
    load(3, 8'h01, 8'h02, 8'h03);
    run_op("abort",     3'd0, 1'b1, 8'h05, 4'b0000, 1'b0, 9, 32'h12, 0, 0, 4);
    load(2, 8'h10, 8'h20, 8'h00);
    run_op("sub_after", 3'd1, 1'b1, 8'hF0, 4'b0110, 1'b0, 9, 32'h12, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop in case the sequence stalls
  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
